// File: rtl/letter_writer.sv
// letter_writer: streams one 3-row glyph frame (lead blank, three glyph
// columns, trail blank) over a valid/ready column interface.
module letter_writer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] letter,
    input  logic       ready,
    output logic [2:0] bits,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        COL0  = 3'd2,
        COL1  = 3'd3,
        COL2  = 3'd4,
        TRAIL = 3'd5
    } state_t;

    state_t     state, nxt_state;
    logic [1:0] ltr, nxt_ltr;
    logic       nxt_done;

    // Column pattern for a given state and glyph; blank outside COL0..COL2.
    function automatic logic [2:0] glyph(input state_t s, input logic [1:0] l);
        logic [2:0] c;
        c = 3'b000;
        case (s)
            COL0: case (l)
                2'd0: c = 3'b111;
                2'd1: c = 3'b101;
                2'd2: c = 3'b100;
                default: c = 3'b111;
            endcase
            COL1: case (l)
                2'd0: c = 3'b001;
                2'd1: c = 3'b111;
                2'd2: c = 3'b111;
                default: c = 3'b001;
            endcase
            COL2: case (l)
                2'd0: c = 3'b001;
                2'd1: c = 3'b101;
                2'd2: c = 3'b100;
                default: c = 3'b111;
            endcase
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // Next-state logic; outside IDLE valid is always 1, so ready alone marks a transfer.
    always_comb begin
        nxt_state = state;
        nxt_ltr   = ltr;
        nxt_done  = 1'b0;
        case (state)
            IDLE: if (start) begin
                nxt_state = LEAD;
                nxt_ltr   = letter;
            end
            LEAD:  if (ready) nxt_state = COL0;
            COL0:  if (ready) nxt_state = COL1;
            COL1:  if (ready) nxt_state = COL2;
            COL2:  if (ready) nxt_state = TRAIL;
            TRAIL: if (ready) begin
                nxt_state = IDLE;
                nxt_done  = 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State register with outputs decoded one step early so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ltr   <= 2'd0;
            bits  <= 3'b000;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            ltr   <= nxt_ltr;
            bits  <= glyph(nxt_state, nxt_ltr);
            valid <= (nxt_state != IDLE);
            busy  <= (nxt_state != IDLE);
            done  <= nxt_done;
        end
    end

endmodule
